hex_marquee: RTL and testbench

HEX_MARQUEE -- requirements
Module: hex_marquee

---
 rtl/hex_pkg.sv | 13 +
 rtl/hex_tick.sv | 36 +++
 rtl/hex_marquee.sv | 129 ++++++++++++
 tb/tb_hex_marquee.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_pkg.sv
// Shared definitions for the hex display blocks: blank pattern, scroller
// state encoding and default buffer depth.
package hex_pkg;

    localparam logic [7:0] BLANK           = 8'hFF;
    localparam int         DEFAULT_MAX_LEN = 8;

    typedef enum logic {
        LOAD   = 1'b0,
        SCROLL = 1'b1
    } state_e;

endpackage

// File: rtl/hex_tick.sv
// Free-running prescaler: one-cycle tick every TICK_DIV enabled cycles.
// Clear wins over enable; the count holds while enable is low.
module hex_tick #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = enable_i && (cnt_q == LAST);
        cnt_d  = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hex_marquee.sv
// Four-digit scrolling marquee: collects a message of 7-segment symbols,
// then scrolls it right-to-left across HEX3..HEX0 once and returns to LOAD.
module hex_marquee
    import hex_pkg::*;
#(
    parameter int TICK_DIV = 12_500_000,
    parameter int MAX_LEN  = DEFAULT_MAX_LEN
) (
    input  logic       CLOCK_50,
    input  logic [1:0] SW,
    input  logic       in_valid,
    input  logic [7:0] in_seg,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] HEX3,
    output logic [7:0] HEX2,
    output logic [7:0] HEX1,
    output logic [7:0] HEX0,
    output logic       busy
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int PW = $clog2(MAX_LEN + 5);

    logic rst, pause;
    assign rst   = SW[0];
    assign pause = SW[1];

    state_e         state_q, state_d;
    logic [LW-1:0]  len_q, len_d;
    logic [PW-1:0]  p_q, p_d;
    logic [3:0][7:0] hex_q, hex_d;
    logic [7:0]     seg_buf_q [MAX_LEN];

    logic xfer, tick, tick_clear, tick_en;

    assign in_ready   = !rst && (state_q == LOAD) && (len_q < LW'(MAX_LEN)) && !pause;
    assign xfer       = in_valid && in_ready;
    assign busy       = (state_q == SCROLL);
    assign tick_clear = (state_q == LOAD);
    assign tick_en    = (state_q == SCROLL) && !pause;

    hex_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_i    (CLOCK_50),
        .rst_i    (rst),
        .clear_i  (tick_clear),
        .enable_i (tick_en),
        .tick_o   (tick)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        p_d     = p_q;
        case (state_q)
            LOAD: begin
                p_d = '0;
                if (xfer) begin
                    len_d = len_q + LW'(1);
                    if (in_last || (len_q == LW'(MAX_LEN - 1))) begin
                        state_d = SCROLL;
                    end
                end
            end
            SCROLL: begin
                // Last step has every character off the left edge.
                if (tick) begin
                    if (p_q == PW'(len_q) + PW'(4)) begin
                        state_d = LOAD;
                        len_d   = '0;
                        p_d     = '0;
                    end else begin
                        p_d = p_q + PW'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Digit j shows virtual character p-1-j; outside the message is blank.
    always_comb begin
        int idx;
        idx   = 0;
        hex_d = '0;
        for (int j = 0; j < 4; j++) begin
            idx      = int'(p_q) - 1 - j;
            hex_d[j] = BLANK;
            if ((idx >= 0) && (idx < int'(len_q))) begin
                hex_d[j] = seg_buf_q[AW'(idx)];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            len_q   <= '0;
            p_q     <= '0;
            hex_q   <= {4{BLANK}};
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            p_q     <= p_d;
            if (state_q == SCROLL) begin
                if (!pause) begin
                    hex_q <= hex_d;
                end
            end else begin
                hex_q <= {4{BLANK}};
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (xfer) begin
            seg_buf_q[AW'(len_q)] <= in_seg;
        end
    end

    assign HEX3 = hex_q[3];
    assign HEX2 = hex_q[2];
    assign HEX1 = hex_q[1];
    assign HEX0 = hex_q[0];

endmodule

// File: tb/tb_hex_marquee.sv
// Bench for hex_marquee with TICK_DIV=4: constant vectors, directed corner
// sequences and random traffic against a queue-based message model.
module tb_hex_marquee;

    localparam int TICK_DIV = 4;
    localparam int MAX_LEN  = 8;

    logic       CLOCK_50 = 1'b0;
    logic [1:0] SW       = 2'b01;
    logic       in_valid = 1'b0;
    logic [7:0] in_seg   = 8'h00;
    logic       in_last  = 1'b0;
    logic       in_ready;
    logic [7:0] HEX3, HEX2, HEX1, HEX0;
    logic       busy;

    hex_marquee #(
        .TICK_DIV (TICK_DIV),
        .MAX_LEN  (MAX_LEN)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .SW       (SW),
        .in_valid (in_valid),
        .in_seg   (in_seg),
        .in_last  (in_last),
        .in_ready (in_ready),
        .HEX3     (HEX3),
        .HEX2     (HEX2),
        .HEX1     (HEX1),
        .HEX0     (HEX0),
        .busy     (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: message queue, scrolling flag, count of unpaused
    // cycles since scrolling began; step position = active / TICK_DIV.
    logic [7:0] msg [$];
    bit         scrolling = 1'b0;
    int         active    = 0;
    logic [7:0] disp [4]  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};

    logic last_acc;
    logic last_ready_seen;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [7:0] vchar(input int i);
        if (i >= 0 && i < msg.size()) return msg[i];
        return 8'hFF;
    endfunction

    function automatic logic model_ready(input logic pz);
        return !scrolling && (msg.size() < MAX_LEN) && !pz;
    endfunction

    task automatic model_reset();
        msg.delete();
        scrolling = 1'b0;
        active    = 0;
        for (int j = 0; j < 4; j++) disp[j] = 8'hFF;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] s, input logic l,
                              input logic pz, input logic rdy);
        if (scrolling && !pz) begin
            for (int j = 0; j < 4; j++) disp[j] = vchar(active / TICK_DIV - 1 - j);
        end else if (!scrolling) begin
            for (int j = 0; j < 4; j++) disp[j] = 8'hFF;
        end
        if (!scrolling) begin
            if (v && rdy) begin
                msg.push_back(s);
                if (l || msg.size() == MAX_LEN) begin
                    scrolling = 1'b1;
                    active    = 0;
                end
            end
        end else if (!pz) begin
            active++;
            if (active / TICK_DIV == msg.size() + 5) begin
                scrolling = 1'b0;
                active    = 0;
                msg.delete();
            end
        end
    endtask

    task automatic chk_outputs();
        chk1("busy", busy, scrolling);
        chk8("HEX0", HEX0, disp[0]);
        chk8("HEX1", HEX1, disp[1]);
        chk8("HEX2", HEX2, disp[2]);
        chk8("HEX3", HEX3, disp[3]);
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic step(input logic v, input logic [7:0] s, input logic l, input logic pz);
        logic rdy;
        in_valid = v;
        in_seg   = s;
        in_last  = l;
        SW[1]    = pz;
        #1;
        rdy             = model_ready(pz);
        last_ready_seen = in_ready;
        chk1("in_ready", in_ready, rdy);
        @(posedge CLOCK_50);
        model_edge(v, s, l, pz, rdy);
        last_acc = v && rdy;
        #1;
        chk_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            idle(1);
            n++;
        end
        chk1(name, busy, 1'b0);
    endtask

    typedef struct {
        logic       valid;
        logic [7:0] seg;
        logic       last;
        logic       pause;
        logic       exp_ready;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int k, n;
        logic [7:0] h0, h1, h2, h3;
        logic cur_v, cur_l, pz;
        logic [7:0] cur_s;

        vecs[0] = '{1'b1, 8'h83, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h83, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h83, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset held over two edges
        for (int i = 0; i < 2; i++) begin
            @(posedge CLOCK_50);
            #1;
            chk8("rst HEX0", HEX0, 8'hFF);
            chk8("rst HEX3", HEX3, 8'hFF);
            chk1("rst busy", busy, 1'b0);
            chk1("rst in_ready", in_ready, 1'b0);
        end
        SW[0] = 1'b0;
        model_reset();

        // Paused transfer attempt, then the 83/88/83/99 message
        for (int i = 0; i < 6; i++) begin
            step(vecs[i].valid, vecs[i].seg, vecs[i].last, vecs[i].pause);
            chk1($sformatf("vec%0d ready", i), last_ready_seen, vecs[i].exp_ready);
            chk1($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
        end
        idle(16);
        chk8("msg4 HEX3", HEX3, 8'h83);
        chk8("msg4 HEX2", HEX2, 8'h88);
        chk8("msg4 HEX1", HEX1, 8'h83);
        chk8("msg4 HEX0", HEX0, 8'h99);
        idle(16);
        chk8("msg4 out HEX3", HEX3, 8'hFF);
        chk8("msg4 out HEX0", HEX0, 8'hFF);
        chk1("msg4 still busy", busy, 1'b1);
        idle(2);
        chk1("msg4 busy before tick9", busy, 1'b1);
        idle(1);
        chk1("msg4 load after tick9", busy, 1'b0);
        chk1("msg4 ready after tick9", in_ready, 1'b1);

        // Single symbol
        step(1'b1, 8'hC0, 1'b1, 1'b0);
        idle(5);
        chk8("one HEX0 tick1", HEX0, 8'hC0);
        chk8("one HEX1 tick1", HEX1, 8'hFF);
        idle(4);
        chk8("one HEX1 tick2", HEX1, 8'hC0);
        chk8("one HEX0 tick2", HEX0, 8'hFF);
        idle(12);
        chk8("one HEX3 tick5", HEX3, 8'hFF);
        chk1("one busy tick5", busy, 1'b1);
        idle(2);
        chk1("one busy before tick6", busy, 1'b1);
        idle(1);
        chk1("one load after tick6", busy, 1'b0);

        // Ten symbols offered without in_last: buffer fills at eight
        k = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'h10 + 8'(k), 1'b0, 1'b0);
            if (last_acc) k++;
        end
        chk8("full accepted", 8'(k), 8'd8);
        n = 2;
        while (busy && n < 200) begin
            idle(1);
            n++;
        end
        chk8("full scroll cycles", 8'(n), 8'd52);

        // Pause mid-scroll
        step(1'b1, 8'hF9, 1'b0, 1'b0);
        step(1'b1, 8'hA4, 1'b0, 1'b0);
        step(1'b1, 8'hB0, 1'b1, 1'b0);
        idle(6);
        chk8("pause pre HEX0", HEX0, 8'hF9);
        h0 = HEX0; h1 = HEX1; h2 = HEX2; h3 = HEX3;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            chk8("paused HEX0", HEX0, h0);
            chk8("paused HEX1", HEX1, h1);
            chk8("paused HEX2", HEX2, h2);
            chk8("paused HEX3", HEX3, h3);
        end
        idle(1);
        chk8("resume1 HEX0", HEX0, 8'hF9);
        idle(1);
        chk8("resume2 HEX0", HEX0, 8'hF9);
        idle(1);
        chk8("resume3 HEX0", HEX0, 8'hA4);
        chk8("resume3 HEX1", HEX1, 8'hF9);
        drain("pause drain");

        // Asynchronous reset between edges mid-scroll
        step(1'b1, 8'hC6, 1'b0, 1'b0);
        step(1'b1, 8'hA1, 1'b1, 1'b0);
        idle(9);
        chk8("pre-rst HEX0", HEX0, 8'hA1);
        chk8("pre-rst HEX1", HEX1, 8'hC6);
        #2;
        SW[0] = 1'b1;
        #1;
        chk8("async HEX0", HEX0, 8'hFF);
        chk8("async HEX1", HEX1, 8'hFF);
        chk8("async HEX2", HEX2, 8'hFF);
        chk8("async HEX3", HEX3, 8'hFF);
        chk1("async busy", busy, 1'b0);
        chk1("async in_ready", in_ready, 1'b0);
        model_reset();
        @(posedge CLOCK_50);
        #1;
        SW[0] = 1'b0;
        step(1'b1, 8'h86, 1'b1, 1'b0);
        chk1("post-rst first transfer", last_acc, 1'b1);
        chk1("post-rst busy", busy, 1'b1);
        drain("post-rst drain");

        // Random traffic with pauses; upstream holds a symbol until taken
        cur_v = 1'b0; cur_s = 8'h00; cur_l = 1'b0;
        last_acc = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!cur_v || last_acc) begin
                cur_v = ($urandom_range(0, 3) != 0);
                cur_s = 8'($urandom);
                cur_l = ($urandom_range(0, 3) == 0);
            end
            pz = ($urandom_range(0, 7) == 0);
            step(cur_v, cur_s, cur_l, pz);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
